// File: rtl/picorv32_mem_arbiter.sv
// Two-requester arbiter for the picorv32 native memory bus with registered outputs and slave timeout.
// Optional round-robin arbitration is enabled by defining PICORV32_ARB_RR_EN (default: fixed priority, port 0 wins).
module picorv32_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s0_valid,
  input  logic        s0_instr,
  input  logic [31:0] s0_addr,
  input  logic [31:0] s0_wdata,
  input  logic [3:0]  s0_wstrb,
  output logic        s0_ready,
  output logic [31:0] s0_rdata,
  input  logic        s1_valid,
  input  logic        s1_instr,
  input  logic [31:0] s1_addr,
  input  logic [31:0] s1_wdata,
  input  logic [3:0]  s1_wstrb,
  output logic        s1_ready,
  output logic [31:0] s1_rdata,
  output logic        m_valid,
  output logic        m_instr,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic        owner,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              grant_s;
  logic              timeout_hit_s;
  logic [31:0]       resp_data_s;

  logic              m_valid_s, m_instr_s, owner_s, busy_s, timeout_err_s;
  logic [31:0]       m_addr_s, m_wdata_s;
  logic [3:0]        m_wstrb_s;
  logic              s0_ready_s, s1_ready_s;
  logic [31:0]       s0_rdata_s, s1_rdata_s;

  assign timeout_hit_s = (TIMEOUT_CYCLES != 32'd0) && (cnt_r == CNT_LAST);
  // A downstream completion on the timeout edge takes precedence over the error.
  assign resp_data_s   = m_ready ? m_rdata : ERR_RDATA;

`ifdef PICORV32_ARB_RR_EN
  logic last_grant_r;

  // Round-robin winner: alternate on contention, otherwise grant the lone requester.
  always_comb begin
    if (s0_valid && s1_valid) begin
      grant_s = ~last_grant_r;
    end else if (s1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Last-grant history; resets to 1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_r <= 1'b1;
    end else if ((state_r == ST_IDLE) && (s0_valid || s1_valid)) begin
      last_grant_r <= grant_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`else
  // Fixed-priority winner: port 0 whenever it is requesting.
  always_comb begin
    if (s0_valid) begin
      grant_s = 1'b0;
    end else if (s1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end
`endif

  // Next-state and next-output logic for the IDLE -> GRANT -> RESP cycle.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    m_valid_s     = m_valid;
    m_instr_s     = m_instr;
    m_addr_s      = m_addr;
    m_wdata_s     = m_wdata;
    m_wstrb_s     = m_wstrb;
    owner_s       = owner;
    busy_s        = busy;
    timeout_err_s = 1'b0;
    s0_ready_s    = 1'b0;
    s1_ready_s    = 1'b0;
    s0_rdata_s    = s0_rdata;
    s1_rdata_s    = s1_rdata;
    case (state_r)
      ST_IDLE: begin
        if (s0_valid || s1_valid) begin
          state_s   = ST_GRANT;
          owner_s   = grant_s;
          m_valid_s = 1'b1;
          busy_s    = 1'b1;
          cnt_s     = '0;
          if (grant_s) begin
            m_instr_s = s1_instr;
            m_addr_s  = s1_addr;
            m_wdata_s = s1_wdata;
            m_wstrb_s = s1_wstrb;
          end else begin
            m_instr_s = s0_instr;
            m_addr_s  = s0_addr;
            m_wdata_s = s0_wdata;
            m_wstrb_s = s0_wstrb;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (cnt_r != CNT_MAX) begin
          cnt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_s = cnt_r;
        end
        if (m_ready || timeout_hit_s) begin
          state_s       = ST_RESP;
          m_valid_s     = 1'b0;
          timeout_err_s = ~m_ready;
          if (owner) begin
            s1_ready_s = 1'b1;
            s1_rdata_s = resp_data_s;
          end else begin
            s0_ready_s = 1'b1;
            s0_rdata_s = resp_data_s;
          end
        end else begin
          state_s = ST_GRANT;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s   = ST_IDLE;
        m_valid_s = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

  // State and registered-output update; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      m_valid     <= 1'b0;
      m_instr     <= 1'b0;
      m_addr      <= 32'd0;
      m_wdata     <= 32'd0;
      m_wstrb     <= 4'd0;
      owner       <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      s0_ready    <= 1'b0;
      s1_ready    <= 1'b0;
      s0_rdata    <= 32'd0;
      s1_rdata    <= 32'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      m_valid     <= m_valid_s;
      m_instr     <= m_instr_s;
      m_addr      <= m_addr_s;
      m_wdata     <= m_wdata_s;
      m_wstrb     <= m_wstrb_s;
      owner       <= owner_s;
      busy        <= busy_s;
      timeout_err <= timeout_err_s;
      s0_ready    <= s0_ready_s;
      s1_ready    <= s1_ready_s;
      s0_rdata    <= s0_rdata_s;
      s1_rdata    <= s1_rdata_s;
    end
  end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Directed, table-driven bench for picorv32_mem_arbiter (instantiated with a 4-cycle timeout).
module tb_picorv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s0_valid, s0_instr, s0_ready;
  logic [31:0] s0_addr, s0_wdata, s0_rdata;
  logic [3:0]  s0_wstrb;
  logic        s1_valid, s1_instr, s1_ready;
  logic [31:0] s1_addr, s1_wdata, s1_rdata;
  logic [3:0]  s1_wstrb;
  logic        m_valid, m_instr, m_ready;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        owner, busy, timeout_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_word;

  always #5 clk = ~clk;

  picorv32_mem_arbiter #(.TIMEOUT_CYCLES(4), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk(clk), .resetn(resetn),
    .s0_valid(s0_valid), .s0_instr(s0_instr), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
    .s0_wstrb(s0_wstrb), .s0_ready(s0_ready), .s0_rdata(s0_rdata),
    .s1_valid(s1_valid), .s1_instr(s1_instr), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
    .s1_wstrb(s1_wstrb), .s1_ready(s1_ready), .s1_rdata(s1_rdata),
    .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        port;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    logic        exp_to;
    int          exp_cyc;
  } vec_t;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete transfer on a port; slave raises m_ready after lat cycles of m_valid.
  task automatic serve(input string nm, input logic port, input logic instr,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                       input int lat, input logic [31:0] rdata, input logic [31:0] exp_rdata,
                       input logic exp_to, input int exp_cyc);
    int   k;
    int   hi;
    logic seen;
    logic other;
    logic [31:0] got;
    if (port) begin
      s1_valid = 1'b1; s1_instr = instr; s1_addr = addr; s1_wdata = wdata; s1_wstrb = wstrb;
    end else begin
      s0_valid = 1'b1; s0_instr = instr; s0_addr = addr; s0_wdata = wdata; s0_wstrb = wstrb;
    end
    tick;
    chk1({nm, " m_valid"}, m_valid, 1'b1);
    chk1({nm, " owner"}, owner, port);
    chk1({nm, " busy"}, busy, 1'b1);
    chk1({nm, " m_instr"}, m_instr, instr);
    chk32({nm, " m_addr"}, m_addr, addr);
    chk32({nm, " m_wdata"}, m_wdata, wdata);
    chk32({nm, " m_wstrb"}, {28'd0, m_wstrb}, {28'd0, wstrb});
    k = 0; hi = 0; seen = 1'b0; other = 1'b0;
    while (!seen && k < 20) begin
      if (m_valid) hi++;
      m_ready = (k == lat);
      m_rdata = rdata;
      if ((k == lat) && (m_addr == 32'h0000_03FC)) begin
        for (int b = 0; b < 4; b++) begin
          if (m_wstrb[b]) mem_word[b*8 +: 8] = m_wdata[b*8 +: 8];
        end
      end
      tick;
      k++;
      seen  = port ? s1_ready : s0_ready;
      other = other | (port ? s0_ready : s1_ready);
    end
    m_ready = 1'b0;
    got = port ? s1_rdata : s0_rdata;
    chk1({nm, " ready pulse"}, seen, 1'b1);
    chk32({nm, " latency"}, 32'(k), 32'(exp_cyc));
    chk32({nm, " m_valid cycles"}, 32'(hi), 32'(exp_cyc));
    chk32({nm, " rdata"}, got, exp_rdata);
    chk1({nm, " timeout_err"}, timeout_err, exp_to);
    chk1({nm, " other ready"}, other, 1'b0);
    chk1({nm, " m_valid dropped"}, m_valid, 1'b0);
    if (port) s1_valid = 1'b0; else s0_valid = 1'b0;
    tick;
    chk1({nm, " ready cleared"}, port ? s1_ready : s0_ready, 1'b0);
    chk1({nm, " timeout cleared"}, timeout_err, 1'b0);
    chk1({nm, " busy cleared"}, busy, 1'b0);
  endtask

  vec_t vecs[6];
  logic exp_o;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_03FC, 32'h0, 4'h0, 2, 32'h0000_0005, 32'h0000_0005, 1'b0, 3};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'hA5A5_A5A5, 4'b0011, 0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0, 1, 32'h0000_0013, 32'h0000_0013, 1'b0, 2};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0, 3, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 4};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 99, 32'h0BAD_0BAD, 32'hDEAD_BEEF, 1'b1, 4};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 99, 32'h0BAD_0BAD, 32'hDEAD_BEEF, 1'b1, 4};

    resetn = 1'b0;
    s0_valid = 1'b0; s0_instr = 1'b0; s0_addr = 32'd0; s0_wdata = 32'd0; s0_wstrb = 4'd0;
    s1_valid = 1'b0; s1_instr = 1'b0; s1_addr = 32'd0; s1_wdata = 32'd0; s1_wstrb = 4'd0;
    m_ready = 1'b0; m_rdata = 32'd0;
    mem_word = 32'd7;
    #12;
    chk1("reset m_valid", m_valid, 1'b0);
    chk1("reset busy", busy, 1'b0);
    chk1("reset owner", owner, 1'b0);
    chk1("reset s0_ready", s0_ready, 1'b0);
    chk1("reset s1_ready", s1_ready, 1'b0);
    chk1("reset timeout_err", timeout_err, 1'b0);
    chk32("reset m_addr", m_addr, 32'd0);
    chk32("reset s0_rdata", s0_rdata, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    tick;

    for (int i = 0; i < 6; i++) begin
      serve($sformatf("vec%0d", i), vecs[i].port, vecs[i].instr, vecs[i].addr, vecs[i].wdata,
            vecs[i].wstrb, vecs[i].lat, vecs[i].rdata, vecs[i].exp_rdata, vecs[i].exp_to,
            vecs[i].exp_cyc);
    end

    // Late m_ready two cycles after a timeout must be discarded.
    serve("late_to", 1'b0, 1'b0, 32'h0000_0048, 32'h0, 4'h0, 99, 32'h0, 32'hDEAD_BEEF, 1'b1, 4);
    tick;
    m_ready = 1'b1; m_rdata = 32'h1111_1111;
    tick;
    m_ready = 1'b0;
    chk1("late s0_ready", s0_ready, 1'b0);
    chk1("late m_valid", m_valid, 1'b0);
    chk1("late busy", busy, 1'b0);
    chk1("late timeout_err", timeout_err, 1'b0);
    tick;
    chk1("late s0_ready+1", s0_ready, 1'b0);
    chk32("late s0_rdata kept", s0_rdata, 32'hDEAD_BEEF);

    // Contention: both held, the winner re-requests immediately after each completion.
    s0_valid = 1'b1; s0_instr = 1'b0; s0_addr = 32'h0000_0200; s0_wdata = 32'd0; s0_wstrb = 4'd0;
    s1_valid = 1'b1; s1_instr = 1'b0; s1_addr = 32'h0000_0300; s1_wdata = 32'd0; s1_wstrb = 4'd0;
    exp_o = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef PICORV32_ARB_RR_EN
      exp_o = 1'(i % 2);
`else
      exp_o = 1'b0;
`endif
      serve($sformatf("cont%0d", i), exp_o, 1'b0, exp_o ? 32'h0000_0300 : 32'h0000_0200, 32'd0,
            4'd0, 1, 32'h0000_1000 + 32'(i), 32'h0000_1000 + 32'(i), 1'b0, 2);
      if (i < 3) begin
        if (exp_o) s1_valid = 1'b1; else s0_valid = 1'b1;
      end
    end
    serve("cont_last", ~exp_o, 1'b0, exp_o ? 32'h0000_0200 : 32'h0000_0300, 32'd0, 4'd0, 0,
          32'h0000_2222, 32'h0000_2222, 1'b0, 1);

    // Asynchronous reset in the middle of a granted transfer.
    s0_valid = 1'b1; s0_addr = 32'h0000_0500; s0_wstrb = 4'd0;
    tick;
    chk1("rst_mid granted", m_valid, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk1("rst_mid m_valid", m_valid, 1'b0);
    chk1("rst_mid busy", busy, 1'b0);
    chk1("rst_mid s0_ready", s0_ready, 1'b0);
    chk32("rst_mid m_addr", m_addr, 32'd0);
    s0_valid = 1'b0;
    tick;
    tick;
    resetn = 1'b1;
    tick;
    tick;
    chk1("rst_after s0_ready", s0_ready, 1'b0);
    chk1("rst_after s1_ready", s1_ready, 1'b0);
    chk1("rst_after m_valid", m_valid, 1'b0);
    serve("rst_new", 1'b0, 1'b0, 32'h0000_0600, 32'd0, 4'd0, 1, 32'h0000_0066, 32'h0000_0066, 1'b0, 2);

    // CPU loop incrementing the word at 0x3FC; the bench slave holds the memory word.
    mem_word = 32'd7;
    for (int i = 0; i < 3; i++) begin
      serve($sformatf("loop_rd%0d", i), 1'b0, 1'b0, 32'h0000_03FC, 32'd0, 4'd0, 1, mem_word,
            32'd7 + 32'(i), 1'b0, 2);
      serve($sformatf("loop_wr%0d", i), 1'b0, 1'b0, 32'h0000_03FC, 32'd8 + 32'(i), 4'hF, 1,
            32'd0, 32'd0, 1'b0, 2);
    end
    chk32("loop mem_word", mem_word, 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
